// File: rtl/rv_loader_pkg.sv
// Shared state encoding and stream-format constants for the IMEM loader.
package rv_loader_pkg;

  typedef enum logic [2:0] {
    S_CNT_LO = 3'd0,
    S_CNT_HI = 3'd1,
    S_DATA   = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } loader_state_e;

  localparam int unsigned CNT_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [1:0]  LAST_LANE  = 2'(WORD_BYTES - 1);

  // The core is held out of reset only while it owns the program.
  function automatic logic is_released(loader_state_e s);
    return (s == S_RUN) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/rv_imem_loader_if.sv
// Byte-stream handshake plus IMEM write port of the loader.
interface rv_imem_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/rv_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o fires with the lane-3 byte.
module rv_byte_packer
  import rv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;

  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (clr_i) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: acc_d        = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

  // The top byte is merged combinationally so the word is ready on its last transfer.
  assign word_valid_o = byte_valid_i && (lane_q == LAST_LANE);
  assign word_o       = {byte_i, acc_q};

endmodule

// File: rtl/rv_imem_loader.sv
// IMEM loader: parses a length-prefixed byte stream into IMEM writes, then releases the core.
//   state  | meaning
//   CNT_LO | waiting for word-count low byte
//   CNT_HI | waiting for word-count high byte
//   DATA   | packing and writing program words
//   RUN    | core released, waiting for done_flag
//   DONE   | program complete; next byte starts a new header
//   ERR    | count exceeded DEPTH; only rst leaves
module rv_imem_loader
  import rv_loader_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  rv_imem_loader_if.master bus,
  output logic             core_rst,
  input  logic             done_flag,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [15:0] DEPTH_N = 16'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [7:0]        cnt_lo_q, cnt_lo_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              core_rst_q, core_rst_d;
  logic              rx_ready, xfer, word_valid;
  logic [15:0]       hdr_n;
  logic [31:0]       word;

  assign rx_ready = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                    (state_q == S_DATA)   || (state_q == S_DONE);
  assign xfer     = bus.rx_valid && rx_ready;
  assign hdr_n    = {bus.rx_data, cnt_lo_q};

  rv_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (state_q != S_DATA),
    .byte_valid_i (xfer && (state_q == S_DATA)),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    count_d  = count_q;
    widx_d   = widx_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    case (state_q)
      S_CNT_LO, S_DONE: begin
        if (xfer) begin
          cnt_lo_d = bus.rx_data;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          count_d = hdr_n;
          widx_d  = '0;
          if (hdr_n == 16'd0)        state_d = S_RUN;
          else if (hdr_n > DEPTH_N)  state_d = S_ERR;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_valid) begin
          we_d    = 1'b1;
          waddr_d = widx_q;
          wdata_d = word;
          // Index saturates at N-1: the last word hands over to RUN instead of wrapping.
          if (16'(widx_q) == count_q - 16'd1) state_d = S_RUN;
          else                                widx_d  = widx_q + 1'b1;
        end
      end
      S_RUN: begin
        if (done_flag) state_d = S_DONE;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_CNT_LO;
    endcase
    // Release lags entry into RUN by one edge but drops on the same edge we leave DONE.
    core_rst_d = is_released(state_q) && is_released(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CNT_LO;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      widx_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      widx_q     <= widx_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = core_rst_q;
  assign busy           = (state_q == S_CNT_HI) || (state_q == S_DATA);
  assign done           = (state_q == S_DONE);
  assign err            = (state_q == S_ERR);

endmodule

// File: tb/tb_rv_imem_loader.sv
// Randomized bench for rv_imem_loader with a stream-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_rv_imem_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_flag = 1'b0;
  logic core_rst, busy, done, err;

  rv_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rv_imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .core_rst  (core_rst),
    .done_flag (done_flag),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: byte-stream parser ----------------
  typedef enum int {P_HDR, P_LOAD, P_RUN, P_DONE, P_ERR} phase_e;
  phase_e            m_phase = P_HDR;
  int                m_hdr = 0;
  int                m_n = 0;
  int                m_bytes = 0;
  logic [7:0]        m_lo = '0;
  logic [7:0]        m_buf [4];
  logic [31:0]       m_imem [DEPTH];
  logic [31:0]       dut_imem [DEPTH];
  logic              e_we = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [31:0]       e_data = '0;
  logic              e_core = 1'b0;
  bit                m_started = 0;

  function automatic bit owns_core(phase_e p);
    return (p == P_RUN) || (p == P_DONE);
  endfunction

  function automatic bit m_ready(phase_e p);
    return (p == P_HDR) || (p == P_LOAD) || (p == P_DONE);
  endfunction

  always @(posedge clk) begin
    phase_e old;
    bit     xfer;
    m_started = 1;
    old  = m_phase;
    xfer = bus.rx_valid && m_ready(m_phase);
    e_we = 1'b0;
    if (rst) begin
      m_phase = P_HDR; m_hdr = 0; m_bytes = 0;
      e_addr = '0; e_data = '0; e_core = 1'b0;
    end else begin
      case (m_phase)
        P_HDR: if (xfer) begin
          if (m_hdr == 0) begin
            m_lo = bus.rx_data; m_hdr = 1;
          end else begin
            m_n = int'({bus.rx_data, m_lo});
            m_hdr = 0; m_bytes = 0;
            if (m_n == 0)          m_phase = P_RUN;
            else if (m_n > DEPTH)  m_phase = P_ERR;
            else                   m_phase = P_LOAD;
          end
        end
        P_LOAD: if (xfer) begin
          m_buf[m_bytes % 4] = bus.rx_data;
          m_bytes++;
          if (m_bytes % 4 == 0) begin
            e_we   = 1'b1;
            e_addr = ADDR_W'(m_bytes / 4 - 1);
            e_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            m_imem[m_bytes / 4 - 1] = e_data;
            if (m_bytes == 4 * m_n) m_phase = P_RUN;
          end
        end
        P_RUN:  if (done_flag) m_phase = P_DONE;
        P_DONE: if (xfer) begin
          m_lo = bus.rx_data; m_hdr = 1; m_phase = P_HDR;
        end
        default: ;
      endcase
      e_core = owns_core(old) && owns_core(m_phase);
    end
  end

  // ---------------- per-cycle compare + DUT-side IMEM image ----------------
  int wr_count = 0, we_run = 0, max_run = 0;
  int cyc = 0, last_we_cyc = 0, rise_cyc = 0;
  logic prev_core = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.imem_we === 1'b1) begin
      dut_imem[bus.imem_waddr] = bus.imem_wdata;
      wr_count++; we_run++; last_we_cyc = cyc;
      if (we_run > max_run) max_run = we_run;
    end else we_run = 0;
    if (core_rst === 1'b1 && prev_core !== 1'b1) rise_cyc = cyc;
    prev_core = core_rst;
    if (m_started) begin
      chk("rx_ready", 32'(bus.rx_ready), 32'(m_ready(m_phase)));
      chk("busy", 32'(busy), 32'((m_phase == P_HDR && m_hdr == 1) || m_phase == P_LOAD));
      chk("done", 32'(done), 32'(m_phase == P_DONE));
      chk("err", 32'(err), 32'(m_phase == P_ERR));
      chk("core_rst", 32'(core_rst), 32'(e_core));
      chk("imem_we", 32'(bus.imem_we), 32'(e_we));
      chk("imem_waddr", 32'(bus.imem_waddr), 32'(e_addr));
      chk("imem_wdata", bus.imem_wdata, e_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_df = 0;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    done_flag    = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (rand_df) done_flag = 1'($urandom_range(1));
    while (bus.rx_ready !== 1'b1 && t < 40) begin tick(); t++; end
    if (t >= 40) begin
      n_cmp++; n_mis++;
      $display("FAIL send_timeout: rx_ready stayed 0, required 1");
    end
    tick();
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      repeat (gap) tick();
    end
  endtask

  task automatic send_list(input logic [7:0] q[$], input int gap);
    foreach (q[i]) send_byte(q[i], gap);
  endtask

  task automatic send_words(input int n, input int gmax);
    for (int w = 0; w < n; w++) begin
      logic [31:0] d;
      d = $urandom;
      for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8], int'($urandom_range(gmax)));
    end
  endtask

  task automatic chk_imem(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_imem[i] !== m_imem[i]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < DEPTH; i++) begin dut_imem[i] = '0; m_imem[i] = '0; end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] prog [$];
    clear_imem();
    bus.rx_valid = 1'b0; bus.rx_data = '0;
    repeat (3) tick();
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd0);
    chk("rst_imem_we", 32'(bus.imem_we), 32'd0);
    chk("rst_waddr_wdata", 32'(bus.imem_waddr) | bus.imem_wdata, 32'd0);
    rst = 1'b0;

    // Two-word program, continuous valid
    prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    wr_count = 0;
    send_list(prog, 0); idle();
    repeat (3) tick();
    chk("t1_wr_count", 32'(wr_count), 32'd2);
    chk("t1_imem0", dut_imem[0], 32'h00500513);
    chk("t1_imem1", dut_imem[1], 32'h00A00093);
    chk("t1_core_rise_lag", 32'(rise_cyc - last_we_cyc), 32'd1);
    done_flag = 1'b1; tick(); done_flag = 1'b0;
    chk("t1_done", 32'(done), 32'd1);

    // Same program with 3-cycle gaps
    pulse_rst(); clear_imem();
    wr_count = 0; max_run = 0;
    send_list(prog, 3); idle();
    repeat (3) tick();
    chk("t2_wr_count", 32'(wr_count), 32'd2);
    chk("t2_imem0", dut_imem[0], 32'h00500513);
    chk("t2_imem1", dut_imem[1], 32'h00A00093);
    chk("t2_we_pulse_width", 32'(max_run), 32'd1);

    // Oversized counts -> sticky error
    pulse_rst(); wr_count = 0;
    send_list('{8'h41, 8'h00}, 0); idle();
    repeat (2) tick();
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    repeat (3) tick(); idle();
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("t3_core_rst", 32'(core_rst), 32'd0);
    chk("t3_no_writes", 32'(wr_count), 32'd0);
    pulse_rst(); tick();
    chk("t3_err_cleared", 32'(err), 32'd0);
    send_list('{8'h00, 8'h01}, 1); idle(); tick();
    chk("t3_err_256", 32'(err), 32'd1);

    // Full-depth load
    pulse_rst(); wr_count = 0;
    send_list('{8'h40, 8'h00}, 0); send_words(DEPTH, 0); idle();
    repeat (2) tick();
    chk("full_wr_count", 32'(wr_count), 32'd64);
    chk("full_last_addr", 32'(bus.imem_waddr), 32'd63);
    chk_imem("full_imem");

    // Zero-length program
    pulse_rst(); wr_count = 0;
    send_list('{8'h00, 8'h00}, 0); idle();
    repeat (2) tick();
    chk("t4_core_rst", 32'(core_rst), 32'd1);
    chk("t4_no_writes", 32'(wr_count), 32'd0);
    done_flag = 1'b1; tick(); done_flag = 1'b0;
    chk("t4_done", 32'(done), 32'd1);

    // Reset after byte 2 of word 1
    pulse_rst(); clear_imem(); wr_count = 0;
    send_list('{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA, 8'hBB}, 0);
    pulse_rst(); tick();
    chk("t5_wr_count", 32'(wr_count), 32'd1);
    chk("t5_imem0", dut_imem[0], 32'h11223344);
    chk("t5_imem1_untouched", dut_imem[1], 32'h0);
    send_list('{8'h02, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'h0B}, 1); idle();
    repeat (2) tick();
    chk("t5_reload0", dut_imem[0], 32'hCAFEF00D);
    chk("t5_reload1", dut_imem[1], 32'h0BADBEEF);

    // Reload from DONE
    done_flag = 1'b1; tick(); done_flag = 1'b0;
    send_byte(8'h01, 0);
    chk("t6_done_cleared", 32'(done), 32'd0);
    chk("t6_core_held", 32'(core_rst), 32'd0);
    send_list('{8'h00, 8'h5A, 8'h5A, 8'hA5, 8'hA5}, 0); idle();
    repeat (2) tick();
    chk("t6_imem0", dut_imem[0], 32'hA5A55A5A);
    chk("t6_core_rereleased", 32'(core_rst), 32'd1);
    chk_imem("t6_imem_model");

    // Randomized loads, headers taken from DONE, aborts and bad counts
    done_flag = 1'b1; tick(); done_flag = 1'b0;
    rand_df = 1;
    for (int r = 0; r < 16; r++) begin
      int n, g, sel;
      sel = int'($urandom_range(9));
      n = (sel == 0) ? 0 : (sel == 1) ? 65 + int'($urandom_range(300)) : 1 + int'($urandom_range(7));
      g = int'($urandom_range(2));
      send_byte(8'(n), g);
      send_byte(8'(n >> 8), g);
      if (n > DEPTH) begin
        idle(); repeat (2) tick();
        chk("rnd_err", 32'(err), 32'd1);
        pulse_rst(); continue;
      end
      if (sel == 2) begin
        int k;
        k = int'($urandom_range(4 * n - 1));
        for (int i = 0; i < k; i++) send_byte(8'($urandom), g);
        pulse_rst(); chk_imem("rnd_abort_imem"); continue;
      end
      send_words(n, g); idle();
      repeat (2) tick();
      chk("rnd_core_rst", 32'(core_rst), 32'd1);
      chk_imem("rnd_imem");
      done_flag = 1'b1; tick(); done_flag = 1'b0;
    end
    rand_df = 0;
    idle(); repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
